// File: rtl/fpu_cmp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_cmp_pkg                                                              |
// | Shared op encodings, class-mask bit positions and NaN constant helper.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fpu_cmp_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_FMIN   = 3'b000;
  localparam logic [OP_W-1:0] OP_FMAX   = 3'b001;
  localparam logic [OP_W-1:0] OP_FEQ    = 3'b010;
  localparam logic [OP_W-1:0] OP_FLT    = 3'b011;
  localparam logic [OP_W-1:0] OP_FLE    = 3'b100;
  localparam logic [OP_W-1:0] OP_FCLASS = 3'b101;

  // One-hot FCLASS mask positions
  localparam int CLS_W        = 10;
  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  // Canonical quiet NaN: +, exponent all ones, mantissa MSB only; callers slice to width
  function automatic logic [127:0] canon_nan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_cmp_classify.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_cmp_classify                                                         |
// | Combinational IEEE-754 class decode for one operand.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fpu_cmp_classify #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] operand,
  output logic                 is_nan,
  output logic                 is_snan,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_sub,
  output logic                 sign
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_exp_ones;
  logic             w_exp_zero;
  logic             w_man_zero;

  assign w_exp      = operand[EXP_W+MAN_W-1:MAN_W];
  assign w_man      = operand[MAN_W-1:0];
  assign w_exp_ones = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_man_zero = ~|w_man;

  assign is_nan  = w_exp_ones & ~w_man_zero;
  assign is_snan = is_nan & ~w_man[MAN_W-1];
  assign is_inf  = w_exp_ones & w_man_zero;
  assign is_zero = w_exp_zero & w_man_zero;
  assign is_sub  = w_exp_zero & ~w_man_zero;
  assign sign    = operand[EXP_W+MAN_W];

endmodule
`default_nettype wire

// File: rtl/fpu_cmp_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_cmp_pipe                                                             |
// | 2-stage FMIN/FMAX/FEQ/FLT/FLE unit; define FPU_CMP_FCLASS_EN to add     |
// | FCLASS on op 101.                                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fpu_cmp_pipe
  import fpu_cmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [OP_W-1:0]        op_i,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic                   nv_o
);

  localparam int           W            = 1 + EXP_W + MAN_W;
  localparam logic [127:0] C_NAN_WIDE   = canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0] C_CANON_NAN  = C_NAN_WIDE[W-1:0];

  // ---------------- S1: classify and magnitude compare ----------------
  logic w_a_nan, w_a_snan, w_a_zero, w_a_inf, w_a_sub, w_a_sign;
  logic w_b_nan, w_b_snan, w_b_zero, w_b_inf, w_b_sub, w_b_sign;

  fpu_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .operand(a_i), .is_nan(w_a_nan), .is_snan(w_a_snan), .is_zero(w_a_zero),
    .is_inf(w_a_inf), .is_sub(w_a_sub), .sign(w_a_sign)
  );

  fpu_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .operand(b_i), .is_nan(w_b_nan), .is_snan(w_b_snan), .is_zero(w_b_zero),
    .is_inf(w_b_inf), .is_sub(w_b_sub), .sign(w_b_sign)
  );

  logic w_mag_lt;
  logic w_mag_eq;
  assign w_mag_lt = a_i[W-2:0] < b_i[W-2:0];
  assign w_mag_eq = a_i[W-2:0] == b_i[W-2:0];

  logic w_unused_cls;
`ifdef FPU_CMP_FCLASS_EN
  logic [CLS_W-1:0] w_cls_mask;
  logic             w_a_norm;
  assign w_a_norm = ~(w_a_nan | w_a_inf | w_a_zero | w_a_sub);
  always_comb begin
    w_cls_mask               = '0;
    w_cls_mask[CLS_NEG_INF]  = w_a_inf  &  w_a_sign;
    w_cls_mask[CLS_NEG_NORM] = w_a_norm &  w_a_sign;
    w_cls_mask[CLS_NEG_SUB]  = w_a_sub  &  w_a_sign;
    w_cls_mask[CLS_NEG_ZERO] = w_a_zero &  w_a_sign;
    w_cls_mask[CLS_POS_ZERO] = w_a_zero & ~w_a_sign;
    w_cls_mask[CLS_POS_SUB]  = w_a_sub  & ~w_a_sign;
    w_cls_mask[CLS_POS_NORM] = w_a_norm & ~w_a_sign;
    w_cls_mask[CLS_POS_INF]  = w_a_inf  & ~w_a_sign;
    w_cls_mask[CLS_SNAN]     = w_a_snan;
    w_cls_mask[CLS_QNAN]     = w_a_nan  & ~w_a_snan;
  end
  assign w_unused_cls = w_b_inf ^ w_b_sub;
`else
  assign w_unused_cls = w_a_inf ^ w_a_sub ^ w_b_inf ^ w_b_sub;
`endif

  // ---------------- Handshake ----------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_adv;
  logic w_s1_adv;

  assign w_s2_adv   = ~r_s2_valid | out_ready_i;
  assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
  assign in_ready_o = w_s1_adv;

  logic [OP_W-1:0]  r_s1_op;
  logic [TAG_W-1:0] r_s1_tag;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic r_s1_a_nan, r_s1_a_snan, r_s1_a_zero, r_s1_a_sign;
  logic r_s1_b_nan, r_s1_b_snan, r_s1_b_zero, r_s1_b_sign;
  logic r_s1_mag_lt, r_s1_mag_eq;
`ifdef FPU_CMP_FCLASS_EN
  logic [CLS_W-1:0] r_s1_cls;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_tag    <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_a_nan  <= 1'b0;
      r_s1_a_snan <= 1'b0;
      r_s1_a_zero <= 1'b0;
      r_s1_a_sign <= 1'b0;
      r_s1_b_nan  <= 1'b0;
      r_s1_b_snan <= 1'b0;
      r_s1_b_zero <= 1'b0;
      r_s1_b_sign <= 1'b0;
      r_s1_mag_lt <= 1'b0;
      r_s1_mag_eq <= 1'b0;
`ifdef FPU_CMP_FCLASS_EN
      r_s1_cls    <= '0;
`endif
    end else begin
      if (flush_i) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_adv) begin
        r_s1_valid <= in_valid_i;
      end
      if (w_s1_adv && in_valid_i && !flush_i) begin
        r_s1_op     <= op_i;
        r_s1_tag    <= tag_i;
        r_s1_a      <= a_i;
        r_s1_b      <= b_i;
        r_s1_a_nan  <= w_a_nan;
        r_s1_a_snan <= w_a_snan;
        r_s1_a_zero <= w_a_zero;
        r_s1_a_sign <= w_a_sign;
        r_s1_b_nan  <= w_b_nan;
        r_s1_b_snan <= w_b_snan;
        r_s1_b_zero <= w_b_zero;
        r_s1_b_sign <= w_b_sign;
        r_s1_mag_lt <= w_mag_lt;
        r_s1_mag_eq <= w_mag_eq;
`ifdef FPU_CMP_FCLASS_EN
        r_s1_cls    <= w_cls_mask;
`endif
      end
    end
  end

  // ---------------- S2: result select and flags ----------------
  // Total order treats -0 < +0; the value order below masks that for compares.
  logic w_tot_lt, w_tot_eq, w_val_lt, w_val_eq;
  logic w_any_nan, w_any_snan, w_both_zero;

  always_comb begin
    w_tot_lt = 1'b0;
    if (r_s1_a_sign != r_s1_b_sign) begin
      w_tot_lt = r_s1_a_sign;
    end else if (!r_s1_a_sign) begin
      w_tot_lt = r_s1_mag_lt;
    end else begin
      w_tot_lt = ~r_s1_mag_lt & ~r_s1_mag_eq;
    end
  end

  assign w_tot_eq    = (r_s1_a_sign == r_s1_b_sign) & r_s1_mag_eq;
  assign w_both_zero = r_s1_a_zero & r_s1_b_zero;
  assign w_val_lt    = ~w_both_zero & w_tot_lt;
  assign w_val_eq    = w_both_zero | w_tot_eq;
  assign w_any_nan   = r_s1_a_nan | r_s1_b_nan;
  assign w_any_snan  = r_s1_a_snan | r_s1_b_snan;

  logic [W-1:0] w_res;
  logic         w_nv;

  always_comb begin
    w_res = '0;
    w_nv  = 1'b0;
    case (r_s1_op)
      OP_FMIN, OP_FMAX: begin
        w_nv = w_any_snan;
        if (r_s1_a_nan && r_s1_b_nan) begin
          w_res = C_CANON_NAN;
        end else if (r_s1_a_nan) begin
          w_res = r_s1_b;
        end else if (r_s1_b_nan) begin
          w_res = r_s1_a;
        end else if (r_s1_op == OP_FMIN) begin
          w_res = (w_tot_lt | w_tot_eq) ? r_s1_a : r_s1_b;
        end else begin
          w_res = w_tot_lt ? r_s1_b : r_s1_a;
        end
      end
      OP_FEQ: begin
        w_res[0] = ~w_any_nan & w_val_eq;
        w_nv     = w_any_snan;
      end
      OP_FLT: begin
        w_res[0] = ~w_any_nan & w_val_lt;
        w_nv     = w_any_nan;
      end
      OP_FLE: begin
        w_res[0] = ~w_any_nan & (w_val_lt | w_val_eq);
        w_nv     = w_any_nan;
      end
`ifdef FPU_CMP_FCLASS_EN
      OP_FCLASS: begin
        w_res[CLS_W-1:0] = r_s1_cls;
      end
`endif
      default: begin
        w_res = '0;
        w_nv  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_s2_valid <= 1'b0;
      result_o   <= '0;
      tag_o      <= '0;
      nv_o       <= 1'b0;
    end else begin
      if (flush_i) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid && !flush_i) begin
        result_o <= w_res;
        tag_o    <= r_s1_tag;
        nv_o     <= w_nv;
      end
    end
  end

  assign out_valid_o = r_s2_valid;

endmodule
`default_nettype wire

// File: doc/fpu_cmp_pipe.md
Name: fpu_cmp_pipe

Overview:
Parametrised, pipelined IEEE-754 comparison unit for the FPU arithmetic path. It executes FMIN, FMAX, FEQ, FLT and FLE for any exponent and mantissa width, with RISC-V NaN and signed-zero semantics. It has a 2-stage pipeline: S1 classifies and compares, S2 selects the result and raises flags. It uses valid/ready handshakes, carries an opaque tag and supports a synchronous flush. It sits between the FPU issue logic and the FP writeback arbiter.

Parameters:
EXP_W, 8, exponent width (8 = single, 11 = double)
MAN_W, 23, stored mantissa width, hidden bit excluded
TAG_W, 5, width of the pass-through tag (destination register index)
W (localparam), 1+EXP_W+MAN_W, operand and result width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous reset, active low
flush_i  in  1  synchronous kill of all in-flight operations
in_valid_i  in  1  request valid
in_ready_o  out  1  unit can accept a request
op_i  in  3  operation: 000 FMIN, 001 FMAX, 010 FEQ, 011 FLT, 100 FLE (others reserved)
a_i  in  W  operand A
b_i  in  W  operand B
tag_i  in  TAG_W  request tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts the result
result_o  out  W  min/max value, or compare bit in LSB zero-extended
tag_o  out  TAG_W  tag of the result
nv_o  out  1  invalid-operation flag for this result

Behaviour:
- Reset (reset_i low, asynchronous): all S1/S2 valid bits = 0; out_valid_o = 0; result_o = 0; tag_o = 0; nv_o = 0. in_ready_o = 1 after release.
- Handshake: a transfer happens when valid and ready are both 1 on the same rising edge.
  - S2 advances when !s2_valid | out_ready_i.
  - S1 advances when !s1_valid | s2_advance.
  - in_ready_o = !s1_valid | s2_advance (combinational from out_ready_i; no path from in_valid_i).
  - Full throughput: 1 op/cycle. Latency: 2 cycles from accept to out_valid_o.
- Stall: while out_valid_o=1 and out_ready_i=0, result_o, tag_o and nv_o hold stable, and S1 holds.
- Flush: flush_i=1 clears both valid bits at the next edge and drops any request offered in that cycle.
  - Flush has priority over a simultaneous input or output handshake; the output handshake in that cycle still counts as consumed.
- Classification (S1):
  - NaN: exp all ones and man != 0. sNaN: NaN with man MSB = 0.
  - Zero: exp = 0 and man = 0. Subnormals compare by raw bits; no flushing.
- Ordering: compare the magnitude {exp,man} unsigned, then apply signs. -0 < +0 for FMIN/FMAX only.
- FMIN/FMAX:
  - Both operands NaN: canonical NaN {0, all-ones exp, 1, zeros}.
  - One operand NaN: return the other operand.
  - Equal values: return A. FMIN(-0,+0) = -0; FMAX(-0,+0) = +0.
  - nv = either operand is sNaN.
- FEQ: 1 iff neither operand is NaN and the values are equal; +0 == -0. nv = either operand is sNaN.
- FLT/FLE: 0 if either operand is NaN; nv = either operand is NaN (quiet or signalling). +0 and -0 compare as equal.
- Reserved op: result 0, nv 0, still flows through the pipeline.
- S1 registers: op, tag, operands, class bits, magnitude-compare result. S2 registers: result, tag, nv.

Optional Feature:
FPU_CMP_FCLASS_EN
- Defined: op 101 = FCLASS on a_i. result_o[9:0] holds the one-hot RISC-V class mask (bit 0 -inf … bit 8 sNaN, bit 9 qNaN); upper bits are zero; nv = 0. Latency and handshake are unchanged.
- Undefined: 101 is reserved (result 0, nv 0) and no classify-mask logic is built.

Decomposition:
- Package fpu_cmp_pkg: op encodings (OP_FMIN…OP_FCLASS), op width, canonical-NaN constant function of EXP_W/MAN_W, class-mask bit indices.
- Sub-module fpu_cmp_classify: combinational, parametrised by EXP_W/MAN_W. Outputs is_nan, is_snan, is_zero, is_inf, is_sub and sign for one operand. It is instantiated twice, for A and B.

Test Plan:
- Single precision, reset then FMIN a=0x3F800000 (1.0), b=0xC0000000 (-2.0) -> out_valid_o 2 cycles later, result 0xC0000000, nv 0.
- FMAX a=0x7F800001 (sNaN), b=0x40400000 -> result 0x40400000, nv 1; FMAX with both operands 0x7FC00000 -> 0x7FC00000, nv 0.
- FEQ a=0x80000000, b=0x00000000 -> result 1, nv 0; FLT a=0x7FC00000, b=0x3F800000 -> result 0, nv 1; FMIN(0x80000000, 0x00000000) -> 0x80000000.
- Back-to-back 8 ops with out_ready_i=1 -> 8 results on consecutive cycles, tags 0..7 in order.
- Back-to-back ops with out_ready_i held 0 for 3 cycles -> output stable, in_ready_o = 0 once both stages are full, no loss or duplication after release.
- flush_i pulsed with both stages full plus an offered request -> no out_valid_o for those three ops; the next request completes normally. Separately: assert reset_i low mid-stream -> all valid outputs drop immediately.
